// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with almost-full/empty thresholds and overflow/underflow pulses; FIFO_PARAM_FWFT_EN selects a first-word-fall-through read port.
// Latency: a write is visible from its own edge, standard read data is registered one cycle; a full FIFO rejects writes unless a read is accepted the same cycle.
module fifo_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  wr_in,
    input  logic                  rd_in,
    output logic [WIDTH-1:0]      data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   fifo_cnt,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ae_q, ae_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_acc;
    logic             rd_acc;

    // A read on empty is refused even if a write lands the same cycle; a write
    // on full goes through only when the head is being popped alongside it.
    always_comb begin
        rd_acc   = rd_in && !empty_q;
        wr_acc   = wr_in && (!full_q || rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_FULL);
        ae_d    = (cnt_d <= AE_C);
        af_d    = (cnt_d >= AF_C);
        ovf_d   = wr_in && !wr_acc;
        udf_d   = rd_in && !rd_acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_PARAM_FWFT_EN
    assign data_out = empty_q ? '0 : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] dout_q;

    // On a full read+write the old head is captured before the same slot is overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem_q[rd_ptr_q];
        end
    end

    assign data_out = dout_q;
`endif

    assign fifo_cnt     = cnt_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a vector table for single-cycle behaviour plus hand sequences for wrap, reset and FWFT.
module tb_fifo_param;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       wr_in;
    logic       rd_in;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [3:0] fifo_cnt;
    logic       overflow;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_param #(
        .WIDTH(8), .DEPTH_LOG2(3), .AF_THRESH(6), .AE_THRESH(2)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_in(wr_in), .rd_in(rd_in),
        .data_out(data_out), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .fifo_cnt(fifo_cnt), .overflow(overflow), .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] dout;
        logic [3:0] cnt;
        logic       e;
        logic       f;
        logic       ae;
        logic       af;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic rd, input logic [7:0] din,
                       input logic [7:0] dout, input logic [3:0] cnt,
                       input logic e, input logic f, input logic ae, input logic af,
                       input logic ovf, input logic udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.dout = dout; v.cnt = cnt;
        v.e = e; v.f = f; v.ae = ae; v.af = af; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [3:0] cnt, input logic e,
                               input logic f, input logic ae, input logic af,
                               input logic ovf, input logic udf);
        check({tag, "_cnt"},  32'(fifo_cnt),     32'(cnt));
        check({tag, "_e"},    32'(empty),        32'(e));
        check({tag, "_f"},    32'(full),         32'(f));
        check({tag, "_ae"},   32'(almost_empty), 32'(ae));
        check({tag, "_af"},   32'(almost_full),  32'(af));
        check({tag, "_ovf"},  32'(overflow),     32'(ovf));
        check({tag, "_udf"},  32'(underflow),    32'(udf));
    endtask

    task automatic step(input logic wr, input logic rd, input logic [7:0] din);
        wr_in = wr; rd_in = rd; data_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_d;

        rst = 1'b0; wr_in = 1'b0; rd_in = 1'b0; data_in = 8'h00;
        #12;
        check("rst_dout", 32'(data_out), 32'h0);
        check_flags("rst", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #10 rst = 1'b1;

        //  wr rd din    dout   cnt e f ae af ov ud
        add(1, 0, 8'h0A, 8'h00, 1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 8'h0B, 8'h00, 2, 0, 0, 1, 0, 0, 0);
        add(1, 0, 8'h0C, 8'h00, 3, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 8'h0A, 2, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'h00, 8'h0B, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'h00, 8'h0C, 0, 1, 0, 1, 0, 0, 0);
        add(0, 1, 8'h00, 8'h0C, 0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 8'h00, 8'h0C, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 8'h10, 8'h0C, 1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 8'h11, 8'h0C, 2, 0, 0, 1, 0, 0, 0);
        add(1, 0, 8'h12, 8'h0C, 3, 0, 0, 0, 0, 0, 0);
        add(1, 0, 8'h13, 8'h0C, 4, 0, 0, 0, 0, 0, 0);
        add(1, 0, 8'h14, 8'h0C, 5, 0, 0, 0, 0, 0, 0);
        add(1, 0, 8'h15, 8'h0C, 6, 0, 0, 0, 1, 0, 0);
        add(1, 0, 8'h16, 8'h0C, 7, 0, 0, 0, 1, 0, 0);
        add(1, 0, 8'h17, 8'h0C, 8, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'hFF, 8'h0C, 8, 0, 1, 0, 1, 1, 0);
        add(0, 0, 8'h00, 8'h0C, 8, 0, 1, 0, 1, 0, 0);
        add(1, 1, 8'h55, 8'h10, 8, 0, 1, 0, 1, 0, 0);
        add(0, 1, 8'h00, 8'h11, 7, 0, 0, 0, 1, 0, 0);
        add(0, 1, 8'h00, 8'h12, 6, 0, 0, 0, 1, 0, 0);
        add(0, 1, 8'h00, 8'h13, 5, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 8'h14, 4, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 8'h15, 3, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 8'h16, 2, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'h00, 8'h17, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'h00, 8'h55, 0, 1, 0, 1, 0, 0, 0);
        add(1, 1, 8'h66, 8'h55, 1, 0, 0, 1, 0, 0, 1);
        add(0, 1, 8'h00, 8'h66, 0, 1, 0, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vecs[i].wr, vecs[i].rd, vecs[i].din);
`ifndef FIFO_PARAM_FWFT_EN
            check({tag, "_dout"}, 32'(data_out), 32'(vecs[i].dout));
`endif
            check_flags(tag, vecs[i].cnt, vecs[i].e, vecs[i].f, vecs[i].ae,
                        vecs[i].af, vecs[i].ovf, vecs[i].udf);
        end

        // Fill, then 20 simultaneous read+write cycles to wrap both pointers.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(8'h20 + i));
            q.push_back(8'(8'h20 + i));
        end
        check("wrap_fill_cnt", 32'(fifo_cnt), 32'd8);
        for (int k = 0; k < 20; k++) begin
`ifdef FIFO_PARAM_FWFT_EN
            check($sformatf("wrap%0d_head", k), 32'(data_out), 32'(q[0]));
`endif
            exp_d = q.pop_front();
            q.push_back(8'(8'h40 + k));
            step(1'b1, 1'b1, 8'(8'h40 + k));
`ifndef FIFO_PARAM_FWFT_EN
            check($sformatf("wrap%0d_dout", k), 32'(data_out), 32'(exp_d));
`endif
            check($sformatf("wrap%0d_cnt", k), 32'(fifo_cnt), 32'd8);
            check($sformatf("wrap%0d_ovf", k), 32'(overflow), 32'd0);
        end
        for (int k = 0; k < 8; k++) begin
`ifdef FIFO_PARAM_FWFT_EN
            check($sformatf("drain%0d_head", k), 32'(data_out), 32'(q[0]));
`endif
            exp_d = q.pop_front();
            step(1'b0, 1'b1, 8'h00);
`ifndef FIFO_PARAM_FWFT_EN
            check($sformatf("drain%0d_dout", k), 32'(data_out), 32'(exp_d));
`endif
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Asynchronous reset in the middle of traffic at count 5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
        check("mid_cnt", 32'(fifo_cnt), 32'd5);
        wr_in = 1'b1; rd_in = 1'b1; data_in = 8'hEE;
        #2 rst = 1'b0;
        #1;
        check("arst_dout", 32'(data_out), 32'h0);
        check_flags("arst", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wr_in = 1'b0; rd_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h33);
        check("post_rst_cnt", 32'(fifo_cnt), 32'd1);
`ifdef FIFO_PARAM_FWFT_EN
        check("fwft_show", 32'(data_out), 32'h33);
`endif
        step(1'b0, 1'b1, 8'h00);
`ifdef FIFO_PARAM_FWFT_EN
        check("post_rst_dout", 32'(data_out), 32'h0);
`else
        check("post_rst_dout", 32'(data_out), 32'h33);
`endif
        check("post_rst_empty", 32'(empty), 32'd1);

`ifdef FIFO_PARAM_FWFT_EN
        step(1'b1, 1'b0, 8'hA5);
        check("fwft_a5", 32'(data_out), 32'hA5);
        step(1'b0, 1'b1, 8'h00);
        check("fwft_pop_dout", 32'(data_out), 32'h0);
        check("fwft_pop_empty", 32'(empty), 32'd1);
`endif
        step(1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the team's 8×8 buffer. Data width and depth are set by parameters. It adds programmable almost-full and almost-empty thresholds, overflow and underflow error pulses, and well-defined behaviour when a read and a write happen in the same cycle. It sits between a producer and a consumer in the same clock domain, and a compile-time option selects a first-word-fall-through read port.

## Interface
- WIDTH, 8: data bits per entry.
- DEPTH_LOG2, 3: log2 of the entry count; depth = 2**DEPTH_LOG2.
- AF_THRESH, 6: almost_full asserts when fifo_cnt >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when fifo_cnt <= AE_THRESH.

- clk  in  1  the single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-low.
- data_in  in  WIDTH  write data, sampled when a write is accepted.
- wr_in  in  1  write request.
- rd_in  in  1  read request.
- data_out  out  WIDTH  read data.
- empty  out  1  fifo_cnt == 0.
- full  out  1  fifo_cnt == 2**DEPTH_LOG2.
- almost_empty  out  1  fifo_cnt <= AE_THRESH.
- almost_full  out  1  fifo_cnt >= AF_THRESH.
- fifo_cnt  out  DEPTH_LOG2+1  number of stored entries.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

## Operation
- Storage is 2**DEPTH_LOG2 entries of WIDTH bits. The array itself is not reset.
- Pointers:
  - wr_ptr and rd_ptr are DEPTH_LOG2 bits wide and wrap naturally from depth-1 to 0.
  - fifo_cnt is a separate (DEPTH_LOG2+1)-bit register.
- Accepted write: wr_in && (!full || rd_acc). Writing while full is accepted only when a read is accepted in the same cycle.
- Accepted read: rd_in && !empty. A read while empty is always rejected, even when a write happens in the same cycle.
- Count update (one step per cycle):
  - write only: fifo_cnt + 1.
  - read only: fifo_cnt − 1.
  - both or neither: unchanged.
- Rejected operations:
  - a rejected write sets overflow high for the following cycle; the array and pointers are unchanged.
  - a rejected read sets underflow high for the following cycle; data_out holds its value.
- Flags:
  - empty, full, almost_empty and almost_full are registered, derived from the next-state count.
  - They therefore change on the same edge as fifo_cnt.
- Thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= depth. Legal threshold values are not checked in RTL.
- Reset (rst low), taking effect immediately and asynchronously:
  - pointers, fifo_cnt, data_out, overflow and underflow go to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - Any write or read in flight is discarded.
  - The first operation is sampled on the first rising edge after rst rises.

## Timing
- Write latency: data written on edge N is readable from edge N onward. empty falls at edge N.
- Standard read: data_out updates at the edge that accepts the read, giving one cycle of latency. It holds its value otherwise.
- Back-to-back operation: one read and/or one write every cycle with no bubbles, at full throughput.
- overflow and underflow are registered, one cycle wide, and asserted once per rejected request.

## Configuration
- FIFO_PARAM_FWFT_EN defined: first-word-fall-through read port.
  - data_out = mem[rd_ptr] combinationally while !empty, and 0 while empty.
  - rd_in pops the head entry; the next entry appears after that edge.
  - A write into an empty FIFO appears on data_out after the write edge, with no read request needed.
- Not defined: standard registered read as described in Timing.

## Test plan
- Reset, then write 0x0A, 0x0B, 0x0C on consecutive cycles, then read 3 times.
  - Standard mode: data_out shows 0x0A, 0x0B, 0x0C, one cycle after each rd_in.
  - fifo_cnt runs 1,2,3,2,1,0, and empty returns to 1.
- Write 8 entries 0x10..0x17, then a 9th write of 0xFF.
  - full=1 and almost_full=1 from count 6.
  - overflow pulses for one cycle; fifo_cnt stays 8.
  - A read-back returns 0x10..0x17 and never 0xFF.
- From empty, assert rd_in for one cycle.
  - underflow pulses for one cycle.
  - fifo_cnt stays 0 and data_out is unchanged.
- While full, assert rd_in and wr_in together with 0x55.
  - Both are accepted, fifo_cnt stays 8, and 0x55 is read out last.
  - With 20 such cycles the pointers wrap and the data order is preserved.
- Pull rst low mid-stream at fifo_cnt=5.
  - All outputs take their reset values immediately.
  - After release, writing 0x33 and reading it back returns 0x33.
- With FIFO_PARAM_FWFT_EN defined, write 0xA5 into an empty FIFO.
  - data_out=0xA5 after the write edge, with rd_in low.
  - After one rd_in, data_out=0 and empty=1.
